// File: rtl/axi_lite_timer_if.sv
// ---------------------------------------------------------------------------
// axi_lite_timer_if
//   AXI4-Lite bus bundle for the timer peripheral.
//   master : drives AW/W/AR address, data and valids, B/R readies
//   slave  : drives AW/W/AR readies, B/R response, data and valids
//   Signal names keep the S_ prefix used by the upstream address decoder.
// ---------------------------------------------------------------------------
interface axi_lite_timer_if;
   logic [31:0] S_AWADDR;
   logic [2:0]  S_AWPROT;
   logic        S_AWVALID;
   logic        S_AWREADY;
   logic [31:0] S_WDATA;
   logic [3:0]  S_WSTRB;
   logic        S_WVALID;
   logic        S_WREADY;
   logic [1:0]  S_BRESP;
   logic        S_BVALID;
   logic        S_BREADY;
   logic [31:0] S_ARADDR;
   logic [2:0]  S_ARPROT;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RVALID;
   logic        S_RREADY;

   modport master (
      output S_AWADDR, S_AWPROT, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
             S_ARADDR, S_ARPROT, S_ARVALID, S_RREADY,
      input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
   );

   modport slave (
      input  S_AWADDR, S_AWPROT, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
             S_ARADDR, S_ARPROT, S_ARVALID, S_RREADY,
      output S_AWREADY, S_WREADY, S_BRESP, S_BVALID, S_ARREADY, S_RDATA, S_RRESP, S_RVALID
   );
endinterface

// File: rtl/axi_lite_timer.sv
// ---------------------------------------------------------------------------
// axi_lite_timer
//   AXI4-Lite slave timer: down-counter with reload, one-shot / auto-reload
//   modes, sticky EXPIRED flag (write-1-to-clear) and a registered level irq.
//   Register map (addr[4:2] decoded, everything else ignored):
//     0x00 CTRL   {IRQ_EN[2], AUTO_RELOAD[1], EN[0]}   lane 0 only
//     0x04 LOAD   byte-strobed
//     0x08 COUNT  byte-strobed, read/write
//     0x0C STATUS {EXPIRED[0]} write-1-to-clear, lane 0 only
//     0x10 PRESCALE (only with AXI_TIMER_PRESCALER_EN defined)
//   Unmapped offsets answer SLVERR with RDATA=0; writes to them are dropped.
//   Optional feature macro: AXI_TIMER_PRESCALER_EN (tick every PRESCALE+1
//   enabled cycles instead of every cycle).
// Ports
//   aclk    : clock
//   aresetn : synchronous, active-low reset
//   s       : AXI4-Lite slave bundle (axi_lite_timer_if.slave)
//   irq     : registered EXPIRED & IRQ_EN
// ---------------------------------------------------------------------------
module axi_lite_timer #(
   parameter int unsigned COUNT_WIDTH = 32,
   parameter logic [31:0] RESET_LOAD  = 32'hFFFF_FFFF
) (
   input  logic             aclk,
   input  logic             aresetn,
   axi_lite_timer_if.slave  s,
   output logic             irq
);

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_LOAD     = 3'd1;
   localparam logic [2:0] OFF_COUNT    = 3'd2;
   localparam logic [2:0] OFF_STATUS   = 3'd3;
   localparam logic [2:0] OFF_PRESCALE = 3'd4;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [COUNT_WIDTH-1:0] LOAD_INIT = COUNT_WIDTH'(RESET_LOAD);

   // Register state
   logic [COUNT_WIDTH-1:0] load_q, count_q;
   logic                   en_q, auto_q, irq_en_q, expired_q, irq_q;

   // Write channel state
   logic        aw_held_q, w_held_q, bvalid_q;
   logic [2:0]  aw_sel_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic [1:0]  bresp_q;

   // Read channel state
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;

   // Combinational helpers
   logic        aw_hs, w_hs, ar_hs, b_hs, wr_commit;
   logic [2:0]  wr_sel;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_ctrl, wr_load, wr_count, wr_status, wr_presc, wr_mapped;
   logic [31:0] rd_data;
   logic        rd_mapped;
   logic        tick, expire;

   // Byte-lane merge of a 32-bit write into an existing register value.
   function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Handshakes
   // ------------------------------------------------------------------
   assign s.S_AWREADY = !aw_held_q && !bvalid_q;
   assign s.S_WREADY  = !w_held_q  && !bvalid_q;
   assign s.S_ARREADY = !rvalid_q;

   assign aw_hs = s.S_AWVALID && s.S_AWREADY;
   assign w_hs  = s.S_WVALID  && s.S_WREADY;
   assign ar_hs = s.S_ARVALID && s.S_ARREADY;
   assign b_hs  = bvalid_q && s.S_BREADY;

   // The register write happens on the edge that completes the later of AW/W;
   // whichever arrived first is taken from its holding register.
   assign wr_commit = (aw_hs || aw_held_q) && (w_hs || w_held_q) && !bvalid_q;
   assign wr_sel    = aw_hs ? s.S_AWADDR[4:2] : aw_sel_q;
   assign wr_data   = w_hs  ? s.S_WDATA       : w_data_q;
   assign wr_strb   = w_hs  ? s.S_WSTRB       : w_strb_q;

   // NOTE: every output of a combinational block gets a default at the top so
   // that no path leaves it unassigned and infers a latch.
   always_comb begin
      wr_ctrl   = 1'b0;
      wr_load   = 1'b0;
      wr_count  = 1'b0;
      wr_status = 1'b0;
      wr_presc  = 1'b0;
      wr_mapped = 1'b1;
      case (wr_sel)
         OFF_CTRL:     wr_ctrl   = wr_commit && wr_strb[0];
         OFF_LOAD:     wr_load   = wr_commit;
         OFF_COUNT:    wr_count  = wr_commit;
         OFF_STATUS:   wr_status = wr_commit && wr_strb[0];
`ifdef AXI_TIMER_PRESCALER_EN
         OFF_PRESCALE: wr_presc  = wr_commit;
`endif
         default:      wr_mapped = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Tick generation
   // ------------------------------------------------------------------
`ifdef AXI_TIMER_PRESCALER_EN
   logic [COUNT_WIDTH-1:0] presc_q, presc_cnt_q;

   assign tick = en_q && (presc_cnt_q == presc_q);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         presc_q     <= '0;
         presc_cnt_q <= '0;
      end else begin
         if (wr_presc)
            presc_q <= COUNT_WIDTH'(merge_strb(32'(presc_q), wr_data, wr_strb));
         // A stopped timer or a new PRESCALE restarts the divider phase.
         if (!en_q || wr_presc || tick)
            presc_cnt_q <= '0;
         else
            presc_cnt_q <= presc_cnt_q + COUNT_WIDTH'(1);
      end
   end
`else
   assign tick = en_q;
`endif

   assign expire = tick && (count_q == '0);

   // ------------------------------------------------------------------
   // Timer registers
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only; where two
   // assignments to the same register fall on one edge, the later statement
   // wins, which is how bus writes take priority over the counter below.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         load_q    <= LOAD_INIT;
         count_q   <= LOAD_INIT;
         en_q      <= 1'b0;
         auto_q    <= 1'b0;
         irq_en_q  <= 1'b0;
         expired_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         if (tick) begin
            if (count_q != '0)
               count_q <= count_q - COUNT_WIDTH'(1);
            else if (auto_q)
               count_q <= load_q;
            else
               en_q <= 1'b0;
         end

         if (wr_ctrl)
            {irq_en_q, auto_q, en_q} <= wr_data[2:0];
         if (wr_load)
            load_q <= COUNT_WIDTH'(merge_strb(32'(load_q), wr_data, wr_strb));
         if (wr_count)
            count_q <= COUNT_WIDTH'(merge_strb(32'(count_q), wr_data, wr_strb));

         // A hardware expiry on the same edge as a W1C keeps the flag set.
         if (expire)
            expired_q <= 1'b1;
         else if (wr_status && wr_data[0])
            expired_q <= 1'b0;

         irq_q <= expired_q && irq_en_q;
      end
   end

   assign irq = irq_q;

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         aw_sel_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_sel_q  <= s.S_AWADDR[4:2];
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= s.S_WDATA;
            w_strb_q <= s.S_WSTRB;
         end
         if (wr_commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
         end else if (b_hs) begin
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end
      end
   end

   assign s.S_BVALID = bvalid_q;
   assign s.S_BRESP  = bresp_q;

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   always_comb begin
      rd_data   = '0;
      rd_mapped = 1'b1;
      case (s.S_ARADDR[4:2])
         OFF_CTRL:     rd_data = {29'd0, irq_en_q, auto_q, en_q};
         OFF_LOAD:     rd_data = 32'(load_q);
         OFF_COUNT:    rd_data = 32'(count_q);
         OFF_STATUS:   rd_data = {31'd0, expired_q};
`ifdef AXI_TIMER_PRESCALER_EN
         OFF_PRESCALE: rd_data = 32'(presc_q);
`endif
         default:      rd_mapped = 1'b0;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else if (ar_hs) begin
         rvalid_q <= 1'b1;
         rdata_q  <= rd_data;
         rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && s.S_RREADY) begin
         rvalid_q <= 1'b0;
      end
   end

   assign s.S_RVALID = rvalid_q;
   assign s.S_RDATA  = rdata_q;
   assign s.S_RRESP  = rresp_q;

   // Address bits outside [4:2] and the PROT fields carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{s.S_AWADDR[31:5], s.S_AWADDR[1:0], s.S_ARADDR[31:5],
                        s.S_ARADDR[1:0], s.S_AWPROT, s.S_ARPROT};

endmodule
